// File: rtl/bram_program_loader_pkg.sv
// Shared definitions for the BRAM program loader: command codes, FSM state
// encodings and the header word layout.
package bram_program_loader_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Header word: [31:24] command, [23:16] channel, [15:0] payload word count.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  chan;
    logic [15:0] count;
  } hdr_t;

endpackage

// File: rtl/loader_hdr_decode.sv
// Combinational header splitter: classifies the command and flags LOAD
// headers whose channel or word count cannot be honoured.
module loader_hdr_decode #(
  parameter int N_CHAN    = 2,
  parameter int MAX_WORDS = 1024,
  parameter int CHAN_W    = 1,
  parameter int CNT_W     = 11
) (
  input  logic [31:0]       hdr_word,
  output logic              is_load,
  output logic              is_start,
  output logic              is_halt,
  output logic              bad_cmd,
  output logic              bad_load,
  output logic [CHAN_W-1:0] chan,
  output logic [CNT_W-1:0]  count
);
  import bram_program_loader_pkg::*;

  hdr_t hdr;

  always_comb begin
    hdr      = hdr_t'(hdr_word);
    is_load  = (hdr.cmd == CMD_LOAD);
    is_start = (hdr.cmd == CMD_START);
    is_halt  = (hdr.cmd == CMD_HALT);
    bad_cmd  = !(is_load || is_start || is_halt);
    // The full 8/16-bit fields are range-checked before any truncation.
    bad_load = (int'(hdr.chan) >= N_CHAN) || (int'(hdr.count) > MAX_WORDS);
    chan     = hdr.chan[CHAN_W-1:0];
    count    = hdr.count[CNT_W-1:0];
  end

endmodule

// File: rtl/bram_program_loader.sv
// Framed stream to BRAM write-port loader with per-frame XOR checksum; holds
// the core stalled until a START command is accepted.
module bram_program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int N_CHAN     = 2,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic [3:0]            w_byte_enb,
  output logic [N_CHAN-1:0]     w_enb,
  output logic                  cpu_stall,
  output logic                  init_done,
  output logic                  busy,
  output logic                  err
);
  import bram_program_loader_pkg::*;

  localparam int IDX_W  = $clog2(MAX_WORDS) + 1;
  localparam int CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic [2:0]            state_q, state_d;
  logic [CHAN_W-1:0]     chan_q, chan_d;
  logic [IDX_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_dat_q, w_dat_d;
  logic [N_CHAN-1:0]     w_enb_q, w_enb_d;
  logic                  cpu_stall_q, cpu_stall_d;
  logic                  init_done_q, init_done_d;
  logic                  err_q, err_d;

  logic              xfer;
  logic              hdr_is_load, hdr_is_start, hdr_is_halt;
  logic              hdr_bad_cmd, hdr_bad_load;
  logic [CHAN_W-1:0] hdr_chan;
  logic [IDX_W-1:0]  hdr_count;

  loader_hdr_decode #(
    .N_CHAN    (N_CHAN),
    .MAX_WORDS (MAX_WORDS),
    .CHAN_W    (CHAN_W),
    .CNT_W     (IDX_W)
  ) u_hdr_decode (
    .hdr_word (s_data[31:0]),
    .is_load  (hdr_is_load),
    .is_start (hdr_is_start),
    .is_halt  (hdr_is_halt),
    .bad_cmd  (hdr_bad_cmd),
    .bad_load (hdr_bad_load),
    .chan     (hdr_chan),
    .count    (hdr_count)
  );

  // s_ready is held low while reset is asserted so the host cannot push early.
  assign s_ready = rst && (state_q != ST_ERROR);
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    count_d  = count_q;
    index_d  = index_q;
    acc_d    = acc_q;
    w_addr_d = w_addr_q;
    w_dat_d  = w_dat_q;
    w_enb_d  = '0;

    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_is_load) begin
            if (hdr_bad_load) begin
              state_d = ST_ERROR;
            end else begin
              chan_d  = hdr_chan;
              count_d = hdr_count;
              index_d = '0;
              acc_d   = '0;
              state_d = (hdr_count == '0) ? ST_CHECK : ST_LOAD;
            end
          end else if (hdr_is_start) begin
            state_d = ST_RUN;
          end else if (hdr_bad_cmd) begin
            state_d = ST_ERROR;
          end
        end
        ST_LOAD: begin
          w_enb_d  = N_CHAN'(1) << chan_q;
          w_addr_d = ADDR_WIDTH'({index_q, 2'b00});
          w_dat_d  = s_data;
          index_d  = index_q + IDX_W'(1);
          acc_d    = acc_q ^ s_data;
          if (index_d == count_q) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = (s_data == acc_q) ? ST_IDLE : ST_ERROR;
        end
        ST_RUN: begin
          if (hdr_is_halt) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Core control follows the next state so it changes on the handshake edge.
    cpu_stall_d = (state_d != ST_RUN);
    init_done_d = (state_d == ST_RUN);
    err_d       = err_q || (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      count_q     <= '0;
      index_q     <= '0;
      acc_q       <= '0;
      w_addr_q    <= '0;
      w_dat_q     <= '0;
      w_enb_q     <= '0;
      cpu_stall_q <= 1'b1;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      count_q     <= count_d;
      index_q     <= index_d;
      acc_q       <= acc_d;
      w_addr_q    <= w_addr_d;
      w_dat_q     <= w_dat_d;
      w_enb_q     <= w_enb_d;
      cpu_stall_q <= cpu_stall_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign w_addr     = w_addr_q;
  assign w_dat      = w_dat_q;
  assign w_enb      = w_enb_q;
  assign w_byte_enb = {4{|w_enb_q}};
  assign cpu_stall  = cpu_stall_q;
  assign init_done  = init_done_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign err        = err_q;

endmodule
